// File: rtl/core_pkg.sv
// Shared decode definitions for the 18-bit core: control word, immediate selector,
// instruction field positions, and the control / immediate helpers used by ID.
package core_pkg;

  localparam int INM_BIT   = 32;
  localparam int TIPO_HI   = 31;
  localparam int TIPO_LO   = 30;
  localparam int OP_HI     = 29;
  localparam int OP_LO     = 28;
  localparam int RD_HI     = 27;
  localparam int RD_LO     = 23;
  localparam int RS1_HI    = 22;
  localparam int RS1_LO    = 18;
  localparam int RS2_HI    = 17;
  localparam int RS2_LO    = 13;
  localparam int IMM13_HI  = 12;
  // Immediates are built at this width and cut down to DATA_W by the stage.
  localparam int IMM_MAX_W = 64;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    logic [2:0] alu_ctrl;
    logic [1:0] rgb;
  } ctrl_t;

  typedef enum logic [1:0] {
    IMM_S13  = 2'b00,
    IMM_S18  = 2'b01,
    IMM_Z13  = 2'b10,
    IMM_NONE = 2'b11
  } imm_src_e;

  typedef struct packed {
    ctrl_t    ctrl;
    imm_src_e imm_src;
  } dec_t;

  function automatic dec_t ctrl_decode(input logic [1:0] tipo,
                                       input logic [1:0] op,
                                       input logic       inm);
    dec_t d;
    d.ctrl    = '0;
    d.imm_src = IMM_NONE;
    case (tipo)
      // ALU: op selects add/sub/and/or, inm picks the immediate operand
      2'b00: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = inm;
        d.ctrl.alu_ctrl  = {1'b0, op};
        d.imm_src        = inm ? IMM_S13 : IMM_NONE;
      end
      2'b01: begin
        case (op)
          2'b00: begin
            d.ctrl.reg_write  = 1'b1;
            d.ctrl.alu_src    = 1'b1;
            d.ctrl.result_src = 1'b1;
            d.imm_src         = IMM_S13;
          end
          2'b01: begin
            d.ctrl.mem_write = 1'b1;
            d.ctrl.alu_src   = 1'b1;
            d.imm_src        = IMM_S13;
          end
          2'b10: begin
            d.ctrl.reg_write = 1'b1;
            d.ctrl.alu_src   = 1'b1;
            d.ctrl.alu_ctrl  = 3'b011;
            d.imm_src        = IMM_Z13;
          end
          default: d.imm_src = IMM_NONE;
        endcase
      end
      2'b10: begin
        d.ctrl.branch   = 1'b1;
        d.ctrl.alu_ctrl = 3'b001;
        d.imm_src       = IMM_S18;
      end
      default: begin
        d.ctrl.rgb     = op;
        d.ctrl.alu_src = inm;
        d.imm_src      = inm ? IMM_S13 : IMM_NONE;
      end
    endcase
    return d;
  endfunction

  function automatic logic [IMM_MAX_W-1:0] imm_extend(input logic [RS2_HI:0] raw,
                                                      input imm_src_e    src);
    logic [IMM_MAX_W-1:0] imm;
    case (src)
      IMM_S13: imm = {{(IMM_MAX_W-13){raw[IMM13_HI]}}, raw[IMM13_HI:0]};
      IMM_S18: imm = {{(IMM_MAX_W-18){raw[RS2_HI]}}, raw};
      IMM_Z13: imm = {{(IMM_MAX_W-13){1'b0}}, raw[IMM13_HI:0]};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// NUM_REGS x DATA_W register file: one write port, two combinational read ports
// with same-cycle write-back bypass; async active-low clear.
module decode_regfile #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 18,
  parameter int REG_AW   = 5,
  parameter int ZERO_R0  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;

  assign wr_ok = we && !((ZERO_R0 != 0) && (wa == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  // A write landing this cycle is visible to readers immediately.
  assign rd1 = ((ZERO_R0 != 0) && (ra1 == '0)) ? '0 :
               (wr_ok && (wa == ra1))           ? wd : regs[ra1];
  assign rd2 = ((ZERO_R0 != 0) && (ra2 == '0)) ? '0 :
               (wr_ok && (wa == ra2))           ? wd : regs[ra2];

endmodule

// File: rtl/decode_stage_param.sv
// ID stage + ID/EX register: decode, bypassed regfile read, immediate extend, load-use bubble.
// Latency 1 cycle; in_ready drops on load-use stall or when EX holds data it will not take.
module decode_stage_param
  import core_pkg::*;
#(
  parameter int DATA_W   = 18,
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int PC_W     = 18,
  parameter int INSTR_W  = 33,
  parameter int ZERO_R0  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [PC_W-1:0]    in_pc_plus4,
  input  logic               wb_we,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               flush,
  input  logic               out_ready,
  output logic               out_valid,
  output ctrl_t              out_ctrl,
  output logic [DATA_W-1:0]  out_rd1,
  output logic [DATA_W-1:0]  out_rd2,
  output logic [DATA_W-1:0]  out_imm,
  output logic [REG_AW-1:0]  out_rs1,
  output logic [REG_AW-1:0]  out_rs2,
  output logic [REG_AW-1:0]  out_rd,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc_plus4,
  output logic               hazard_stall
);

  logic                 inm;
  logic [1:0]           tipo;
  logic [1:0]           op;
  logic [REG_AW-1:0]    rd;
  logic [REG_AW-1:0]    rs1;
  logic [REG_AW-1:0]    rs2;
  dec_t                 dec;
  logic [IMM_MAX_W-1:0] imm_full;
  logic [DATA_W-1:0]    rf_rd1;
  logic [DATA_W-1:0]    rf_rd2;
  logic                 ex_rd_zero;
  logic                 load_use;
  logic                 ex_free;

  assign inm  = in_instr[INM_BIT];
  assign tipo = in_instr[TIPO_HI:TIPO_LO];
  assign op   = in_instr[OP_HI:OP_LO];
  assign rd   = REG_AW'(in_instr[RD_HI:RD_LO]);
  assign rs1  = REG_AW'(in_instr[RS1_HI:RS1_LO]);
  assign rs2  = REG_AW'(in_instr[RS2_HI:RS2_LO]);

  assign dec      = ctrl_decode(tipo, op, inm);
  assign imm_full = imm_extend(in_instr[RS2_HI:0], dec.imm_src);

  decode_regfile #(
    .NUM_REGS(NUM_REGS),
    .DATA_W  (DATA_W),
    .REG_AW  (REG_AW),
    .ZERO_R0 (ZERO_R0)
  ) u_regfile (
    .clk(clk),
    .rst(rst),
    .we (wb_we),
    .wa (wb_rd),
    .wd (wb_data),
    .ra1(rs1),
    .ra2(rs2),
    .rd1(rf_rd1),
    .rd2(rf_rd2)
  );

  // A load targeting r0 produces nothing a consumer could wait for.
  assign ex_rd_zero = (ZERO_R0 != 0) && (out_rd == '0);
  assign load_use   = out_valid && out_ctrl.result_src && out_ctrl.reg_write &&
                      !ex_rd_zero && ((out_rd == rs1) || (out_rd == rs2));

  assign hazard_stall = in_valid && load_use && !flush;
  assign ex_free      = !out_valid || out_ready;
  // Flush swallows the ID instruction, so ID must always look consumed.
  assign in_ready     = flush || (!hazard_stall && ex_free);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_ctrl     <= '0;
      out_rd1      <= '0;
      out_rd2      <= '0;
      out_imm      <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_pc       <= '0;
      out_pc_plus4 <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (hazard_stall && ex_free) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid    <= 1'b1;
      out_ctrl     <= dec.ctrl;
      out_rd1      <= rf_rd1;
      out_rd2      <= rf_rd2;
      out_imm      <= DATA_W'(imm_full);
      out_rs1      <= rs1;
      out_rs2      <= rs2;
      out_rd       <= rd;
      out_pc       <= in_pc;
      out_pc_plus4 <= in_pc_plus4;
    end else if (out_ready) begin
      // Drained with nothing behind it: keep control zero so EX sees a clean bubble.
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end
  end

endmodule

// File: doc/decode_stage_param.md
Name: decode_stage_param

Overview:
Parametrised ID stage plus ID/EX pipeline register for the 18-bit pipelined core. It decodes the instruction, reads the register file with write-back bypass, and extends the immediate. It registers everything toward EX behind a valid/ready handshake. It adds three capabilities: load-use stall detection, flush, and full-width PC propagation.

Parameters:
DATA_W, 18, register/immediate/result width
NUM_REGS, 32, architectural registers; register 0 reads as zero when ZERO_R0=1
REG_AW, 5, register index width (clog2 of NUM_REGS)
PC_W, 18, PC width carried to EX (not truncated)
INSTR_W, 33, instruction width
ZERO_R0, 1, 1 = r0 hardwired to zero and writes to it ignored

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  IF/ID holds a valid instruction
in_ready  out  1  stage accepts the instruction this cycle
in_instr  in  INSTR_W  instruction
in_pc  in  PC_W  PC of instruction
in_pc_plus4  in  PC_W  PC+4
wb_we  in  1  write-back enable
wb_rd  in  REG_AW  write-back destination
wb_data  in  DATA_W  write-back data
flush  in  1  kill the instruction in ID and in the EX register (taken branch)
out_ready  in  1  EX accepts out_* this cycle
out_valid  out  1  out_* hold a valid instruction
out_ctrl  out  ctrl_t  packed {reg_write, alu_src, mem_write, result_src, branch, alu_ctrl[2:0], rgb[1:0]}
out_rd1, out_rd2, out_imm  out  DATA_W  operands and extended immediate
out_rs1, out_rs2, out_rd  out  REG_AW  source and destination indices
out_pc, out_pc_plus4  out  PC_W  propagated PCs
hazard_stall  out  1  load-use bubble inserted this cycle

Behaviour:
- Fields: inm=instr[32], tipo=[31:30], op=[29:28], rd=[27:23], rs1=[22:18], rs2=[17:13].
- Control decode follows the core's existing control-unit truth table, with imm_src[1:0] as an additional output.
- Immediate by imm_src:
  - 00: sign-extend [12:0]
  - 01: sign-extend [17:0]
  - 10: zero-extend [12:0]
  - 11: zero
  - Results are truncated or extended to DATA_W.
- Register file: write on posedge clk when wb_we and not (ZERO_R0 and wb_rd==0).
- Read is combinational with bypass: if wb_we and wb_rd==rsX and a write is allowed, rdX = wb_data in the same cycle. r0 reads 0 when ZERO_R0=1.
- Load-use: load_use = out_valid & out_ctrl.result_src & out_ctrl.reg_write & (out_rd==rs1 | out_rd==rs2). With ZERO_R0=1, out_rd==0 never triggers.
- hazard_stall = in_valid & load_use & ~flush.
- in_ready = ~hazard_stall & (~out_valid | out_ready).
- EX register update, evaluated in priority order each posedge clk:
  1. flush=1: out_valid<=0. The ID instruction is consumed (in_ready forced 1) and discarded.
  2. Else if hazard_stall and (~out_valid | out_ready): load a bubble (out_valid<=0, out_ctrl<=0). The ID instruction is held.
  3. Else if in_valid & in_ready: load all out_* from decode; out_valid<=1.
  4. Else if out_ready: out_valid<=0.
  5. Else hold all outputs.
- Latency: 1 cycle from acceptance to out_valid.
- Throughput: 1 instruction/cycle with no hazard.
- A load-use hazard costs exactly one bubble cycle.
- Bubble/invalid: whenever out_valid=0, out_ctrl must be all-zero, so EX never writes regs or memory.
- Reset (rst=0, async): out_valid=0 and every out_* = 0. Register file cleared to 0. hazard_stall is combinational and 0 by construction.
- Reset mid-operation discards both the ID and EX instructions. No state survives.
- Simultaneous wb write and read of the same register: bypass value wins.
- Simultaneous flush and hazard: flush wins and no bubble is counted.

Decomposition:
- Package core_pkg holds:
  - ctrl_t packed struct
  - imm_src_e enum
  - field position localparams
  - function ctrl_decode(tipo, op, inm) returning {ctrl_t, imm_src}
  - function imm_extend
- One sub-module: decode_regfile (NUM_REGS x DATA_W, 2 read ports with bypass, 1 write port, async active-low clear).

Test Plan:
- Reset with out_* forced non-zero, rst=0 -> all outputs 0 and out_valid=0. After release, first accepted ADD (rd=3, rs1=1, rs2=2) yields out_valid=1 one cycle later.
- wb_we=1, wb_rd=5, wb_data=18'h2A5A5 while ID reads rs1=5 -> out_rd1=18'h2A5A5 on the next edge. Writing r0=18'h3FFFF then reading r0 -> 0.
- EX holds a load with rd=7 and ID instr has rs2=7 -> hazard_stall=1 and in_ready=0 for one cycle, and EX gets a bubble (out_ctrl=0). The next cycle the instruction issues with the forwarded register value.
- flush=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the ID instruction is not issued, even if a load-use condition was present.
- out_ready=0 for 3 cycles with in_valid=1 -> out_* stable and in_ready=0. On out_ready=1, the pending instruction is accepted on that edge.
- imm_src=00 with instr[12:0]=13'h1FFF -> out_imm=18'h3FFFF. imm_src=10 with the same bits -> out_imm=18'h01FFF. PC 18'h2F004 -> out_pc=18'h2F004 (full width preserved).
